// File: rtl/updown_counter_pkg.sv
// Shared constants and parameter checks for counter/timer/prescaler blocks.
package updown_counter_pkg;

  localparam bit MODE_WRAP = 1'b0;
  localparam bit MODE_SAT  = 1'b1;

  // Legal count register widths for this family of blocks.
  function automatic bit width_ok(input int w);
    return (w >= 2) && (w <= 32);
  endfunction

endpackage

// File: rtl/updown_counter_step.sv
// Next-count computation for the up/down counter: one step in the requested
// direction, with wrap or saturate handling at 0 and MAX_VAL.
module count_step
  import updown_counter_pkg::*;
#(
  parameter int              WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = '1,
  parameter bit              SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  output logic [WIDTH-1:0] next_count,
  output logic             at_limit
);

  // At a limit the step would leave 0..MAX_VAL; otherwise a plain +/-1.
  always_comb begin
    at_limit   = up ? (count == MAX_VAL) : (count == '0);
    next_count = count;
    if (up) begin
      if (at_limit) next_count = (SATURATE == MODE_SAT) ? MAX_VAL : '0;
      else          next_count = count + WIDTH'(1);
    end else begin
      if (at_limit) next_count = (SATURATE == MODE_SAT) ? '0 : MAX_VAL;
      else          next_count = count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/updown_counter.sv
// Parametrised up/down counter: range 0..MAX_VAL, synchronous load/clear,
// wrap or saturate at the limits, terminal-count and sticky limit flags.
module updown_counter
  import updown_counter_pkg::*;
#(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter bit              SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap,
  output logic             limit
);

  localparam logic [WIDTH-1:0] MAXV = MAX_VAL[WIDTH-1:0];

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("updown_counter: WIDTH %0d outside 2..32", WIDTH);
  end
  if ((MAX_VAL < 64'd1) || (MAX_VAL > ((64'd1 << WIDTH) - 64'd1))) begin : g_bad_max
    $error("updown_counter: MAX_VAL %0d outside 1..2**WIDTH-1", MAX_VAL);
  end

  // Loaded values above the range are pulled down to MAX_VAL.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  logic [WIDTH-1:0] next_count;
  logic             at_limit;

  count_step #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAXV),
    .SATURATE (SATURATE)
  ) u_step (
    .count      (out),
    .up         (up),
    .next_count (next_count),
    .at_limit   (at_limit)
  );

  // Terminal count: this edge will produce a wrap/saturation event.
  assign tc = en & at_limit & ~load & ~clear & ~reset;

  // Count register and flags with reset > clear > load > en priority.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      out   <= '0;
      wrap  <= 1'b0;
      limit <= 1'b0;
    end else if (load) begin
      out  <= clamp_load(load_val);
      wrap <= 1'b0;
    end else if (en) begin
      out  <= next_count;
      wrap <= at_limit;
      if (at_limit) limit <= 1'b1;
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_updown_counter.sv
// Bench for updown_counter: three configurations share one set of inputs,
// each is tracked by an arithmetic reference model; config A also runs a
// directed vector table, plus hand sequences for priority/reset/saturation.
module tb_updown_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0, clear = 1'b0, load = 1'b0, en = 1'b0, up = 1'b0;
  logic [7:0] load_val = 8'd0;

  logic [7:0] out_a, out_b;
  logic [3:0] out_c;
  logic       tc_a, tc_b, tc_c, wrap_a, wrap_b, wrap_c, limit_a, limit_b, limit_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  updown_counter #(.WIDTH(8), .MAX_VAL(9), .SATURATE(1'b0)) dut_a (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
    .en(en), .up(up), .out(out_a), .tc(tc_a), .wrap(wrap_a), .limit(limit_a));

  updown_counter #(.WIDTH(8), .MAX_VAL(5), .SATURATE(1'b1)) dut_b (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
    .en(en), .up(up), .out(out_b), .tc(tc_b), .wrap(wrap_b), .limit(limit_b));

  updown_counter #(.WIDTH(4), .MAX_VAL(15), .SATURATE(1'b0)) dut_c (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val[3:0]),
    .en(en), .up(up), .out(out_c), .tc(tc_c), .wrap(wrap_c), .limit(limit_c));

  // Reference model state per configuration (A, B, C).
  int m_max[3] = '{9, 5, 15};
  bit m_sat[3] = '{1'b0, 1'b1, 1'b0};
  int m_out[3] = '{0, 0, 0};
  bit m_wrap[3] = '{1'b0, 1'b0, 1'b0};
  bit m_lim[3] = '{1'b0, 1'b0, 1'b0};

  typedef struct {
    bit       r, c, l;
    bit [7:0] lv;
    bit       e, u;
    int       eo;
    bit       etc, ew, el;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_tc(input int i);
    if (reset || clear || load || !en) return 1'b0;
    return up ? (m_out[i] == m_max[i]) : (m_out[i] == 0);
  endfunction

  // Range arithmetic: wrap is modulo MAX+1, saturate clamps into 0..MAX.
  function automatic void model_step(input int i);
    int lvm, n;
    lvm = (i == 2) ? (int'(load_val) % 16) : int'(load_val);
    if (reset || clear) begin
      m_out[i] = 0; m_wrap[i] = 1'b0; m_lim[i] = 1'b0;
    end else if (load) begin
      m_out[i] = (lvm < m_max[i]) ? lvm : m_max[i];
      m_wrap[i] = 1'b0;
    end else if (en) begin
      n = m_out[i] + (up ? 1 : -1);
      if (n < 0 || n > m_max[i]) begin
        m_wrap[i] = 1'b1;
        m_lim[i]  = 1'b1;
        if (m_sat[i]) n = (n < 0) ? 0 : m_max[i];
        else          n = (n + m_max[i] + 1) % (m_max[i] + 1);
      end else begin
        m_wrap[i] = 1'b0;
      end
      m_out[i] = n;
    end else begin
      m_wrap[i] = 1'b0;
    end
  endfunction

  bit last_tc_a;

  // Apply one cycle of inputs, check tc before the edge, outputs after it.
  task automatic step(input bit r_i, c_i, l_i, input logic [7:0] lv_i,
                      input bit e_i, u_i);
    reset = r_i; clear = c_i; load = l_i; load_val = lv_i; en = e_i; up = u_i;
    #1;
    last_tc_a = tc_a;
    chk("tc_a", int'(tc_a), int'(model_tc(0)));
    chk("tc_b", int'(tc_b), int'(model_tc(1)));
    chk("tc_c", int'(tc_c), int'(model_tc(2)));
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
    chk("out_a", int'(out_a), m_out[0]);
    chk("out_b", int'(out_b), m_out[1]);
    chk("out_c", int'(out_c), m_out[2]);
    chk("wrap_a", int'(wrap_a), int'(m_wrap[0]));
    chk("wrap_b", int'(wrap_b), int'(m_wrap[1]));
    chk("wrap_c", int'(wrap_c), int'(m_wrap[2]));
    chk("limit_a", int'(limit_a), int'(m_lim[0]));
    chk("limit_b", int'(limit_b), int'(m_lim[1]));
    chk("limit_c", int'(limit_c), int'(m_lim[2]));
  endtask

  task automatic expect_a(input string name, input int eo, input bit ew, el);
    chk({name, "_out"}, int'(out_a), eo);
    chk({name, "_wrap"}, int'(wrap_a), int'(ew));
    chk({name, "_limit"}, int'(limit_a), int'(el));
  endtask

  initial begin
    // Directed vectors for MAX_VAL=9 wrap mode.
    vecs.push_back('{1, 0, 0, 8'd0, 0, 0, 0, 0, 0, 0});
    for (int k = 1; k <= 12; k++)
      vecs.push_back('{0, 0, 0, 8'd0, 1, 1, k % 10, (k == 10), (k == 10), (k >= 10)});
    vecs.push_back('{0, 0, 1, 8'd200, 0, 0, 9, 0, 0, 1});
    for (int k = 1; k <= 11; k++)
      vecs.push_back('{0, 0, 0, 8'd0, 1, 0, (k <= 9) ? 9 - k : 19 - k,
                       (k == 10), (k == 10), 1});

    @(posedge clk); #1;
    foreach (vecs[j]) begin
      step(vecs[j].r, vecs[j].c, vecs[j].l, vecs[j].lv, vecs[j].e, vecs[j].u);
      chk($sformatf("vec%0d_tc", j), int'(last_tc_a), int'(vecs[j].etc));
      expect_a($sformatf("vec%0d", j), vecs[j].eo, vecs[j].ew, vecs[j].el);
    end

    // Priority: clear beats load/en/up, then load alone takes effect.
    step(0, 0, 1, 8'd3, 0, 0);
    expect_a("prio_setup", 3, 0, 1);
    step(0, 1, 1, 8'd7, 1, 1);
    expect_a("prio_clear", 0, 0, 0);
    step(0, 0, 1, 8'd7, 0, 0);
    expect_a("prio_load", 7, 0, 0);

    // Reset mid-count overrides en and load.
    step(0, 0, 1, 8'd9, 0, 0);
    step(0, 0, 0, 8'd0, 1, 1);
    expect_a("rst_wrap", 0, 1, 1);
    step(0, 0, 1, 8'd6, 0, 0);
    step(1, 0, 1, 8'd4, 1, 1);
    expect_a("rst_mid", 0, 0, 0);
    step(0, 0, 0, 8'd0, 1, 1);
    expect_a("rst_resume", 1, 0, 0);

    // Saturation on config B: sticks at 5 with wrap held, then steps down.
    step(1, 0, 0, 8'd0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 0, 8'd0, 1, 1);
      chk($sformatf("sat%0d_out", k), int'(out_b), (k < 5) ? k : 5);
      chk($sformatf("sat%0d_wrap", k), int'(wrap_b), int'(k >= 6));
      chk($sformatf("sat%0d_limit", k), int'(limit_b), int'(k >= 6));
    end
    step(0, 0, 0, 8'd0, 1, 0);
    chk("sat_down_out", int'(out_b), 4);
    chk("sat_down_wrap", int'(wrap_b), 0);
    chk("sat_down_limit", int'(limit_b), 1);

    // Full-range modulus on config C: 0 - 1 -> 15.
    step(1, 0, 0, 8'd0, 0, 0);
    step(0, 0, 0, 8'd0, 1, 0);
    chk("full_tc", int'(tc_c) | 0, 0);
    chk("full_out", int'(out_c), 15);
    chk("full_wrap", int'(wrap_c), 1);
    chk("full_limit", int'(limit_c), 1);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 9) == 0, 8'($urandom),
           $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/updown_counter.md
# updown_counter

Parametrised up/down counter with programmable terminal value, synchronous load and clear, and a choice of wrap or saturate behaviour at the range limits. It supersedes the fixed-width free-running counter in the same library. It is the general-purpose timing and event counter for datapath sequencing, timeouts and test benches. Count range is 0..MAX_VAL inclusive. A terminal-count output and a sticky limit flag let control logic react without decoding the count.

## Interface
- WIDTH, 8, count register width; legal 2..32
- MAX_VAL, 2**WIDTH-1, inclusive upper bound of count range; must satisfy 1 <= MAX_VAL <= 2**WIDTH-1
- SATURATE, 0, 0 = wrap at limits, 1 = hold at limits
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-high reset
- clear  input  1  synchronous clear of count and flags
- load  input  1  synchronous load of load_val
- load_val  input  WIDTH  value to load; clamped to MAX_VAL
- en  input  1  count enable
- up  input  1  direction: 1 = increment, 0 = decrement
- out  output  WIDTH  current count (registered)
- tc  output  1  terminal count (combinational from registered state and inputs)
- wrap  output  1  registered one-cycle pulse after a wrap or saturation event
- limit  output  1  sticky flag: a limit was crossed or hit since the last clear/reset

## Operation
- Priority per cycle: reset > clear > load > en. Lower-priority inputs are ignored when a higher one is asserted.
- reset: out=0, wrap=0, limit=0.
- clear: same effect as reset. Used in-band by control logic.
- load: out <= min(load_val, MAX_VAL). wrap <= 0. limit is unchanged. en and up are ignored that cycle.
- en=1, up=1, out<MAX_VAL: out <= out+1.
- en=1, up=0, out>0: out <= out-1.
- en=1, up=1, out==MAX_VAL:
  - SATURATE=0: out <= 0.
  - SATURATE=1: out holds MAX_VAL.
  - In both modes: wrap <= 1, limit <= 1.
- en=1, up=0, out==0:
  - SATURATE=0: out <= MAX_VAL.
  - SATURATE=1: out holds 0.
  - In both modes: wrap <= 1, limit <= 1.
- en=0, no load/clear: out holds. wrap <= 0.
- tc = en & (up ? out==MAX_VAL : out==0) & ~load & ~clear & ~reset. It is asserted in the same cycle as the event that produces wrap on the next edge.
- Arithmetic is modulo MAX_VAL+1, never modulo 2**WIDTH. Values above MAX_VAL are unreachable except transiently via load_val, which is clamped.
- up may change every cycle; direction takes effect on the same edge.

## Timing
- out latency: 1 cycle from any control input to the new count.
- wrap: asserted exactly the cycle after tc was high. Back-to-back limit events (saturate mode, en held) keep wrap high continuously.
- limit: set on the edge after the first tc. It stays high until clear or reset.
- Reset mid-count: the next edge forces all outputs to 0 regardless of en, load or clear.
- No combinational path from load_val to out. The only combinational output is tc.

## Structure
- Shared package: mode constants MODE_WRAP=0 and MODE_SAT=1, and the WIDTH legality check function. The package is reused by future timer and prescaler blocks.
- One natural sub-module, count_step: purely combinational. It takes out, up, MAX_VAL and SATURATE, and returns next_count and at_limit.
- The top level holds the registers, the priority mux and flag logic.
- Parameter checks run at elaboration and fail on illegal WIDTH/MAX_VAL.

## Test plan
- WIDTH=8, MAX_VAL=9, SATURATE=0; reset then en=1 up=1 for 12 cycles -> out 1,2…9,0,1,2; tc high while out=9; wrap high the cycle out=0; limit=1 from then on.
- Same config, load=1 load_val=200 -> out=9 next cycle (clamped). Then up=0 for 11 cycles -> 8…0,9,8; wrap pulse after the 0->9 step.
- SATURATE=1, MAX_VAL=5; count up 8 cycles from 0 -> out sticks at 5; wrap stays high for every cycle en held at 5; limit=1. Then up=0 -> 4 next cycle; wrap=0.
- Priority: from out=3, assert load(load_val=7), en, up and clear together -> out=0, limit=0. Next cycle load alone -> out=7.
- reset asserted mid-count at out=6 with en=1 and load=1 -> out=0, wrap=0, limit=0 on the next edge. Deassert -> counting resumes from 0 at 1.
- WIDTH=4, MAX_VAL=15, SATURATE=0; decrement from 0 -> out=15, wrap pulse. Verifies the full-range modulus equals 2**WIDTH.
